// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared state encoding, bus timing defaults and RTC register map
package rtc_pkg;

   // Bus sequencer states (legacy-compatible encoding)
   localparam int         ST_W        = 4;
   localparam logic [3:0] ST_IDLE     = 4'd0;
   localparam logic [3:0] ST_A_SETUP  = 4'd1;
   localparam logic [3:0] ST_A_STROBE = 4'd2;
   localparam logic [3:0] ST_A_HOLD   = 4'd3;
   localparam logic [3:0] ST_GAP      = 4'd4;
   localparam logic [3:0] ST_D_SETUP  = 4'd5;
   localparam logic [3:0] ST_D_STROBE = 4'd6;
   localparam logic [3:0] ST_D_HOLD   = 4'd7;
   localparam logic [3:0] ST_DONE     = 4'd8;
   localparam logic [3:0] ST_RECOVER  = 4'd9;

   // Default phase lengths in clk cycles
   localparam int T_SETUP_DEF   = 2;
   localparam int T_PULSE_DEF   = 4;
   localparam int T_HOLD_DEF    = 2;
   localparam int T_GAP_DEF     = 3;
   localparam int T_RECOVER_DEF = 2;
   localparam int CNT_W_DEF     = 4;

   // RTC register addresses shared with the init/sequencer FSMs
   localparam logic [7:0] RTC_REG_CTRL     = 8'h02;
   localparam logic [7:0] RTC_REG_SEG      = 8'h21;
   localparam logic [7:0] RTC_REG_MIN      = 8'h22;
   localparam logic [7:0] RTC_REG_HORA     = 8'h23;
   localparam logic [7:0] RTC_REG_DIA      = 8'h24;
   localparam logic [7:0] RTC_REG_MES      = 8'h25;
   localparam logic [7:0] RTC_REG_ANIO     = 8'h26;
   localparam logic [7:0] RTC_REG_TRANSFER = 8'hF1;

endpackage

// File: rtl/rtc_phase_timer.sv
// rtl/rtc_phase_timer.sv - loadable down-counter that times one bus phase
module rtc_phase_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] value,
   output logic             zero
);

   logic [CNT_W-1:0] count;

   // load on phase entry, otherwise count down and park at zero
   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (load)
         count <= value;
      else if (count != '0)
         count <= count - 1'b1;
   end

   assign zero = (count == '0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// rtl/rtc_bus_ctrl.sv - two-phase RTC address/data bus stage; RTC_BUS_VERIFY_EN adds write read-back
module rtc_bus_ctrl
   import rtc_pkg::*;
#(
   parameter int T_SETUP   = T_SETUP_DEF,
   parameter int T_PULSE   = T_PULSE_DEF,
   parameter int T_HOLD    = T_HOLD_DEF,
   parameter int T_GAP     = T_GAP_DEF,
   parameter int T_RECOVER = T_RECOVER_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       escritura,
   input  logic       lectura,
   input  logic [7:0] dir,
   input  logic [7:0] dato,
   output logic       fin,
   output logic       ocupado,
   output logic [7:0] dato_leido,
   output logic [7:0] ad_out,
   input  logic [7:0] ad_in,
   output logic       ad_oe,
   output logic       cs_n,
   output logic       rd_n,
   output logic       wr_n,
   output logic       a_d
`ifdef RTC_BUS_VERIFY_EN
  ,output logic       err_verif
`endif
);

   logic [ST_W-1:0]  state, state_nxt;
   logic             cmd_valid, cmd_rd;
   logic [7:0]       dir_q, dato_q;
   logic             tmr_load, tmr_zero;
   logic [CNT_W-1:0] tmr_val;
   logic             accept, capture, rd_eff, verify_next;

   // A request is taken only from a quiet IDLE; the latched command starts the bus one edge later
   assign accept  = (state == ST_IDLE) && !cmd_valid && (escritura || lectura);
   assign capture = (state == ST_D_STROBE) && tmr_zero;

`ifdef RTC_BUS_VERIFY_EN
   logic verif_q;
   assign rd_eff      = cmd_rd | verif_q;
   assign verify_next = !cmd_rd && !verif_q;
`else
   assign rd_eff      = cmd_rd;
   assign verify_next = 1'b0;
`endif

   rtc_phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk   (clk),
      .reset (reset),
      .load  (tmr_load),
      .value (tmr_val),
      .zero  (tmr_zero)
   );

   // next state: each timed phase advances when its counter reaches zero
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:     if (cmd_valid) state_nxt = ST_A_SETUP;
         ST_A_SETUP:  if (tmr_zero)  state_nxt = ST_A_STROBE;
         ST_A_STROBE: if (tmr_zero)  state_nxt = ST_A_HOLD;
         ST_A_HOLD:   if (tmr_zero)  state_nxt = ST_GAP;
         ST_GAP:      if (tmr_zero)  state_nxt = ST_D_SETUP;
         ST_D_SETUP:  if (tmr_zero)  state_nxt = ST_D_STROBE;
         ST_D_STROBE: if (tmr_zero)  state_nxt = ST_D_HOLD;
         ST_D_HOLD:   if (tmr_zero)  state_nxt = verify_next ? ST_A_SETUP : ST_DONE;
         ST_DONE:                    state_nxt = ST_RECOVER;
         ST_RECOVER:  if (tmr_zero)  state_nxt = ST_IDLE;
         default:                    state_nxt = ST_IDLE;
      endcase
   end

   // phase length is loaded as T-1 whenever a new phase is entered
   always_comb begin
      tmr_load = (state_nxt != state);
      case (state_nxt)
         ST_A_SETUP, ST_D_SETUP:   tmr_val = CNT_W'(T_SETUP - 1);
         ST_A_STROBE, ST_D_STROBE: tmr_val = CNT_W'(T_PULSE - 1);
         ST_A_HOLD, ST_D_HOLD:     tmr_val = CNT_W'(T_HOLD - 1);
         ST_GAP:                   tmr_val = CNT_W'(T_GAP - 1);
         ST_RECOVER:               tmr_val = CNT_W'(T_RECOVER - 1);
         default:                  tmr_val = '0;
      endcase
   end

   // state register, command latch and read-data capture while rd_n is still low
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         cmd_valid  <= 1'b0;
         cmd_rd     <= 1'b0;
         dir_q      <= '0;
         dato_q     <= '0;
         dato_leido <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            dir_q     <= dir;
            dato_q    <= dato;
            cmd_rd    <= !escritura;
            cmd_valid <= 1'b1;
         end else if (state == ST_IDLE) begin
            cmd_valid <= 1'b0;
         end
         if (capture && cmd_rd)
            dato_leido <= ad_in;
      end
   end

`ifdef RTC_BUS_VERIFY_EN
   // read-back pass after a write: compared at the end of its read strobe
   always_ff @(posedge clk) begin
      if (reset) begin
         verif_q   <= 1'b0;
         err_verif <= 1'b0;
      end else begin
         if ((state == ST_D_HOLD) && (state_nxt == ST_A_SETUP))
            verif_q <= 1'b1;
         else if (state == ST_DONE)
            verif_q <= 1'b0;
         if (accept)
            err_verif <= 1'b0;
         else if (capture && verif_q)
            err_verif <= (ad_in != dato_q);
      end
   end
`endif

   // registered bus outputs decoded from the state being entered
   always_ff @(posedge clk) begin
      if (reset) begin
         cs_n    <= 1'b1;
         rd_n    <= 1'b1;
         wr_n    <= 1'b1;
         a_d     <= 1'b0;
         ad_oe   <= 1'b0;
         ad_out  <= '0;
         fin     <= 1'b0;
         ocupado <= 1'b0;
      end else begin
         cs_n    <= 1'b1;
         rd_n    <= 1'b1;
         wr_n    <= 1'b1;
         a_d     <= 1'b0;
         ad_oe   <= 1'b0;
         ad_out  <= '0;
         fin     <= (state_nxt == ST_DONE);
         ocupado <= (state_nxt != ST_IDLE) || accept;
         case (state_nxt)
            ST_A_SETUP, ST_A_STROBE, ST_A_HOLD: begin
               cs_n   <= 1'b0;
               ad_oe  <= 1'b1;
               ad_out <= dir_q;
               wr_n   <= (state_nxt != ST_A_STROBE);
            end
            ST_D_SETUP, ST_D_STROBE, ST_D_HOLD: begin
               cs_n   <= 1'b0;
               a_d    <= 1'b1;
               ad_oe  <= !rd_eff;
               ad_out <= rd_eff ? 8'h00 : dato_q;
               if (state_nxt == ST_D_STROBE) begin
                  rd_n <= !rd_eff;
                  wr_n <= rd_eff;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb/tb_rtc_bus_ctrl.sv - randomized self-checking bench for rtc_bus_ctrl, RTC_BUS_VERIFY_EN aware
module tb_rtc_bus_ctrl;
   import rtc_pkg::*;

   localparam int TS    = T_SETUP_DEF;
   localparam int TP    = T_PULSE_DEF;
   localparam int TH    = T_HOLD_DEF;
   localparam int TG    = T_GAP_DEF;
   localparam int PHASE = TS + TP + TH;
   localparam int PASS  = PHASE + TG + PHASE;
`ifdef RTC_BUS_VERIFY_EN
   localparam int WR_PASSES = 2;
`else
   localparam int WR_PASSES = 1;
`endif

   typedef struct {
      bit         ad;
      bit         rd;
      logic [7:0] val;
      int         len;
   } strobe_t;

   logic       clk = 1'b0;
   logic       reset, escritura, lectura;
   logic [7:0] dir, dato, chip_val;
   logic       fin, ocupado, ad_oe, cs_n, rd_n, wr_n, a_d;
   logic [7:0] dato_leido, ad_out, ad_in;
`ifdef RTC_BUS_VERIFY_EN
   logic       err_verif;
`endif

   // chip model: only drives the real value while the read strobe is low
   assign ad_in = rd_n ? ~chip_val : chip_val;

   rtc_bus_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .escritura  (escritura),
      .lectura    (lectura),
      .dir        (dir),
      .dato       (dato),
      .fin        (fin),
      .ocupado    (ocupado),
      .dato_leido (dato_leido),
      .ad_out     (ad_out),
      .ad_in      (ad_in),
      .ad_oe      (ad_oe),
      .cs_n       (cs_n),
      .rd_n       (rd_n),
      .wr_n       (wr_n),
      .a_d        (a_d)
`ifdef RTC_BUS_VERIFY_EN
     ,.err_verif  (err_verif)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // bus monitor state
   int         cyc = 0;
   int         fin_cnt, fin_cyc, fin_run, fin_max, viol, hi;
   bit         in_run, seen_low, cur_rd;
   strobe_t    cur_s;
   strobe_t    obs[$];
   int         gaps[$];
   logic [7:0] dato_at_fin, exp_last;
   logic       ocup_at_fin;
   logic       err_at_fin;

   task automatic clear_logs();
      obs.delete();
      gaps.delete();
      fin_cnt = 0; fin_run = 0; fin_max = 0; viol = 0;
      in_run = 0; seen_low = 0; hi = 0;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!wr_n || !rd_n) begin
            if (!in_run) begin
               cur_s.ad  = a_d;
               cur_s.rd  = !rd_n;
               cur_s.val = ad_out;
               cur_s.len = 0;
               in_run    = 1;
            end
            cur_s.len++;
         end else if (in_run) begin
            obs.push_back(cur_s);
            in_run = 0;
         end
         if ((ad_oe && !rd_n) || (!wr_n && !rd_n) || (ad_oe && cs_n) || (cur_rd && ad_oe && a_d))
            viol++;
         if (fin) begin
            if (fin_run == 0) begin
               fin_cnt++;
               fin_cyc     = cyc;
               dato_at_fin = dato_leido;
               ocup_at_fin = ocupado;
`ifdef RTC_BUS_VERIFY_EN
               err_at_fin  = err_verif;
`else
               err_at_fin  = 1'b0;
`endif
            end
            fin_run++;
            if (fin_run > fin_max) fin_max = fin_run;
            seen_low = 0;
            hi       = 0;
         end else begin
            fin_run = 0;
            if (!cs_n) begin
               if (seen_low && hi > 0) gaps.push_back(hi);
               seen_low = 1;
               hi       = 0;
            end else if (seen_low && ocupado) begin
               hi++;
            end else begin
               hi = 0;
            end
         end
      end
   end

   // one command from request to idle; expectations built from the bus rules
   task automatic run_cmd(input bit wr, input bit rd, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] cv, input int drop_dly);
      strobe_t exp_q[$];
      strobe_t s;
      int      c0, k, passes;
      clear_logs();
      escritura = wr; lectura = rd; dir = a; dato = d; chip_val = cv; cur_rd = !wr;
      c0 = cyc;
      @(posedge clk); #2;
`ifdef RTC_BUS_VERIFY_EN
      check("err_clear", err_verif, 0);
`endif
      dir  = 8'($urandom);
      dato = 8'($urandom);
      k = 0;
      while (fin_cnt == 0 && k < 200) begin
         @(posedge clk); #2;
         k++;
      end
      repeat (drop_dly) begin @(posedge clk); #2; end
      escritura = 0; lectura = 0;
      repeat (8) begin @(posedge clk); #2; end

      passes = wr ? WR_PASSES : 1;
      for (int p = 0; p < passes; p++) begin
         s.ad = 0; s.rd = 0; s.val = a; s.len = TP; exp_q.push_back(s);
         s.ad = 1; s.rd = !wr || (p > 0); s.val = d; s.len = TP; exp_q.push_back(s);
      end
      if (!wr) exp_last = cv;

      check("fin_cnt", fin_cnt, 1);
      check("fin_lat", fin_cyc - c0 - 2, 1 + passes * PASS);
      check("fin_width", fin_max, 1);
      check("ocup_at_fin", ocup_at_fin, 1);
      check("ocup_idle", ocupado, 0);
      check("n_strobe", obs.size(), exp_q.size());
      if (obs.size() == exp_q.size()) begin
         for (int i = 0; i < exp_q.size(); i++) begin
            check("strobe_ad", obs[i].ad, exp_q[i].ad);
            check("strobe_rd", obs[i].rd, exp_q[i].rd);
            check("strobe_len", obs[i].len, exp_q[i].len);
            if (!exp_q[i].rd) check("strobe_val", obs[i].val, exp_q[i].val);
         end
      end
      check("n_gap", gaps.size(), passes);
      foreach (gaps[i]) check("gap_len", gaps[i], TG);
      check("tristate", viol, 0);
      check("dato_leido", dato_at_fin, exp_last);
`ifdef RTC_BUS_VERIFY_EN
      check("err_verif", err_at_fin, wr && (cv != d));
`endif
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int k;
      bit w, r;
      logic [7:0] a, d, cv;
      reset = 1; escritura = 0; lectura = 0; dir = 0; dato = 0; chip_val = 0;
      cur_rd = 0; exp_last = 0;
      repeat (3) @(posedge clk);
      #2;
      check("rst_cs_n", cs_n, 1);
      check("rst_rd_n", rd_n, 1);
      check("rst_wr_n", wr_n, 1);
      check("rst_a_d", a_d, 0);
      check("rst_ad_oe", ad_oe, 0);
      check("rst_ad_out", ad_out, 0);
      check("rst_fin", fin, 0);
      check("rst_ocupado", ocupado, 0);
      check("rst_dato_leido", dato_leido, 0);
`ifdef RTC_BUS_VERIFY_EN
      check("rst_err_verif", err_verif, 0);
`endif
      reset = 0;
      @(posedge clk); #2;

      // directed: plain write, plain read, both requests together
      run_cmd(1, 0, RTC_REG_CTRL, 8'h10, 8'h10, 1);
      run_cmd(0, 1, RTC_REG_HORA, 8'h00, 8'h0C, 0);
      run_cmd(1, 1, RTC_REG_SEG, 8'h37, 8'h37, 1);

      // request held through fin; upstream swaps address/data two edges later
      clear_logs();
      cur_rd = 0; chip_val = 8'h31;
      escritura = 1; lectura = 0; dir = RTC_REG_DIA; dato = 8'h31;
      k = 0;
      while (fin_cnt < 1 && k < 200) begin @(posedge clk); #2; k++; end
      dir = RTC_REG_MES; dato = 8'h12;
      k = 0;
      while (fin_cnt < 2 && k < 200) begin @(posedge clk); #2; k++; end
      escritura = 0;
      repeat (10) begin @(posedge clk); #2; end
      check("b2b_fin_cnt", fin_cnt, 2);
      check("b2b_n_strobe", obs.size(), 4 * WR_PASSES);
      if (obs.size() == 4 * WR_PASSES) begin
         check("b2b_addr1", obs[0].val, RTC_REG_DIA);
         check("b2b_data1", obs[1].val, 8'h31);
         check("b2b_addr2", obs[2 * WR_PASSES].val, RTC_REG_MES);
         check("b2b_data2", obs[2 * WR_PASSES + 1].val, 8'h12);
      end

      // reset during the data strobe aborts without fin
      clear_logs();
      cur_rd = 0; escritura = 1; dir = RTC_REG_MIN; dato = 8'h59;
      k = 0;
      while (!(wr_n == 0 && a_d == 1) && k < 100) begin @(posedge clk); #2; k++; end
      check("abort_reach", k < 100, 1);
      reset = 1;
      @(posedge clk); #2;
      check("abort_cs_n", cs_n, 1);
      check("abort_wr_n", wr_n, 1);
      check("abort_rd_n", rd_n, 1);
      check("abort_ad_oe", ad_oe, 0);
      check("abort_fin", fin, 0);
      check("abort_ocupado", ocupado, 0);
      reset = 0; escritura = 0; exp_last = 0;
      repeat (10) begin @(posedge clk); #2; end
      check("abort_no_fin", fin_cnt, 0);
      run_cmd(1, 0, RTC_REG_MIN, 8'h59, 8'h59, 0);

`ifdef RTC_BUS_VERIFY_EN
      // read-back mismatch flagged, then cleared by the next accepted request
      run_cmd(1, 0, RTC_REG_SEG, 8'h44, 8'h00, 0);
      run_cmd(0, 1, RTC_REG_SEG, 8'h00, 8'h44, 0);
`endif

      // randomized commands
      for (int i = 0; i < 40; i++) begin
         k  = int'($urandom_range(0, 2));
         w  = (k != 1);
         r  = (k != 0);
         a  = 8'($urandom);
         d  = 8'($urandom);
         cv = ($urandom_range(0, 1) == 1) ? d : 8'($urandom);
         run_cmd(w, r, a, d, cv, int'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rtc_bus_ctrl.md
Name: rtc_bus_ctrl

Overview:
- Physical bus stage for the RTC chip's multiplexed 8-bit address/data bus.
- Consumes one-register commands from the RTC init/sequencer FSMs (dir, dato, escritura/lectura) and runs a two-phase bus cycle: address, then data.
- Returns a one-cycle fin pulse per completed command; returns read data on dato_leido.
- Sits between the RTC control FSMs and the FPGA tristate pads.

Parameters:
T_SETUP, 2, cycles CS/A_D/AD valid before strobe (>=1)
T_PULSE, 4, cycles WR_n/RD_n held low (>=1)
T_HOLD, 2, cycles AD/CS held after strobe release (>=1)
T_GAP, 3, cycles CS high between address and data phase (>=1)
T_RECOVER, 2, cycles after fin before a new request is sampled (>=2)
CNT_W, 4, phase counter width; must hold max(T_*)-1

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
escritura  in  1  write request (level, held until fin)
lectura  in  1  read request (level, held until fin)
dir  in  8  register address
dato  in  8  write data
fin  out  1  one-cycle completion pulse
ocupado  out  1  high from accept through end of RECOVER
dato_leido  out  8  last read data
ad_out  out  8  value driven on AD pads
ad_in  in  8  AD pad input
ad_oe  out  1  1 = FPGA drives AD
cs_n  out  1  chip select, active low
rd_n  out  1  read strobe, active low
wr_n  out  1  write strobe, active low
a_d  out  1  0 = address phase, 1 = data phase

Behaviour:
- Reset and polarity: "reset reset, synchronous, active-high; clock clk."
- Reset values: cs_n=1, rd_n=1, wr_n=1, a_d=0, ad_oe=0, ad_out=0, fin=0, ocupado=0, dato_leido=0; state IDLE.
- Reset mid-transaction aborts at the next edge; no fin is produced.
- All outputs are registered.
- Requests are sampled only in IDLE.
  - escritura has priority over lectura when both are high.
  - On accept: latch dir, dato and command type; later changes on the inputs are ignored until IDLE.
- States and bus values:
  - IDLE: bus inactive.
  - A_SETUP (T_SETUP): cs_n=0, a_d=0, ad_oe=1, ad_out=dir latch.
  - A_STROBE (T_PULSE): as A_SETUP, plus wr_n=0. The address is always written.
  - A_HOLD (T_HOLD): strobe released; other signals held.
  - GAP (T_GAP): cs_n=1, ad_oe=0.
  - D_SETUP (T_SETUP): cs_n=0, a_d=1.
    - Write: ad_oe=1, ad_out=dato latch.
    - Read: ad_oe=0.
  - D_STROBE (T_PULSE): write drives wr_n=0; read drives rd_n=0.
  - D_HOLD (T_HOLD): strobes high.
  - DONE (1 cycle): fin=1, bus inactive.
  - RECOVER (T_RECOVER): then IDLE.
- Phase timing: one down-counter, loaded with T-1 on phase entry; the phase advances when it reaches 0. Each phase lasts exactly T cycles.
- Read capture: ad_in is captured into dato_leido at the edge that ends D_STROBE, while rd_n is still low. dato_leido holds until the next read.
- Latency with defaults: DONE begins 19 cycles after A_SETUP begins (A_SETUP starts one edge after the accepting edge).
- RECOVER >= 2 exists because the upstream FSM advances its registered outputs only 2 edges after fin. During those cycles the stale request stays high and must not be re-accepted.
- Tristate safety:
  - ad_oe=0 in GAP and throughout the read data phase.
  - ad_oe never high while rd_n=0.
  - wr_n and rd_n are never low simultaneously.

Optional Feature:
- Macro: RTC_BUS_VERIFY_EN.
- Defined:
  - After each write's D_HOLD, run an internal read of the same address (full address+data sequence, no GAP skip) before DONE.
  - Compare the read-back value to the dato latch.
  - New output err_verif (1 bit, reset 0) is set on mismatch and cleared on the next accepted request.
  - fin is delayed accordingly.
- Undefined: no extra states, no err_verif port; write latency as above.

Decomposition:
- Shared package rtc_pkg:
  - state encoding localparams;
  - default timing constants;
  - RTC register address constants shared with the init/sequencer FSMs.
- One sub-module, rtc_phase_timer: CNT_W down-counter with load/value inputs and a zero flag.

Test Plan:
- Write dir=8'h02, dato=8'h10, defaults:
  - wr_n low exactly 4 cycles with a_d=0 and ad_out=8'h02, then 4 cycles with a_d=1 and ad_out=8'h10;
  - cs_n high 3 cycles between phases;
  - fin high exactly 1 cycle, 20 edges after accept.
- Read dir=8'h23 with ad_in=8'h0C during D_STROBE:
  - ad_oe=0 in the data phase, rd_n low 4 cycles;
  - dato_leido=8'h0C when fin rises.
- escritura held high through fin while upstream-style logic changes dir/dato 2 cycles after fin: exactly one transaction per command, the new values are used, no duplicate.
- escritura=lectura=1 in IDLE: write performed; rd_n never asserts.
- Reset asserted during D_STROBE: next edge gives cs_n=wr_n=rd_n=1, ad_oe=0, no fin; a new request after reset completes normally.
- With RTC_BUS_VERIFY_EN, ad_in forced to 8'h00 on a write of 8'h44: err_verif=1 at fin; the next accepted request clears it.
